// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter.
//   - DEF_* : default requester count and datapath widths
//   - slot_state_t : occupancy of the single response slot
//   - resp_t : packed response view {id, carry, sum} for the default configuration
package adder_share_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_ID_W  = $clog2(DEF_N_REQ);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic                 carry;
        logic [DEF_WIDTH-1:0] sum;
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans req starting at rr_ptr, wrapping modulo N_REQ, and picks the first set bit.
//   req         : request vector
//   rr_ptr      : index with the highest priority this cycle
//   enable      : when low, no grant is issued
//   grant       : one-hot-or-zero grant
//   winner      : encoded index of the first requester found (0 when none)
//   grant_valid : a grant is issued this cycle
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  winner,
    output logic             grant_valid
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            // N_REQ is a power of two, so ID_W-bit overflow is the wrap.
            idx = rr_ptr + ID_W'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        grant_valid = enable & found;
        grant       = '0;
        if (grant_valid) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one registered adder lane between N_REQ requesters.
// A round-robin arbiter grants at most one request per cycle; the registered sum is
// returned on a single response slot tagged with the winner's index and held under
// backpressure.
//   clock, reset              : clock and asynchronous active-high reset
//   req_valid/req_ready       : per-requester handshake (ready is one-hot-or-zero)
//   req_a, req_b              : packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready     : response handshake
//   resp_sum/resp_carry/resp_id : truncated sum, carry-out and winner index
//   done_count                : responses consumed, wraps silently
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ID_W  = $clog2(N_REQ),
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_sum,
    output logic                   resp_carry,
    output logic [ID_W-1:0]        resp_id,
    output logic [CNT_W-1:0]       done_count
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             carry;
        logic [WIDTH-1:0] sum;
    } slot_t;

    slot_state_t      state_q, state_d;
    slot_t            slot_q, slot_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;

    logic             can_issue;
    logic             grant_valid;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  winner;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH:0]   sum_full;

    // The slot can take a new result if it is empty or is being drained this cycle.
    assign can_issue = (state_q == ST_EMPTY) | resp_ready;

    // Gating with reset keeps req_ready low for the whole reset window.
    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .enable      (can_issue & ~reset),
        .grant       (grant),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;

    // Operand select for the winning requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (winner == ID_W'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        rr_ptr_d     = rr_ptr_q;
        done_count_d = done_count_q;

        if (resp_valid && resp_ready) begin
            done_count_d = done_count_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_EMPTY: begin
                if (grant_valid) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // A grant in the same cycle as a drain keeps the slot full (no bubble).
                if (resp_ready && !grant_valid) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (grant_valid) begin
            slot_d.id    = winner;
            slot_d.carry = sum_full[WIDTH];
            slot_d.sum   = sum_full[WIDTH-1:0];
            rr_ptr_d     = winner + ID_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            slot_q       <= '0;
            rr_ptr_q     <= '0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            rr_ptr_q     <= rr_ptr_d;
            done_count_q <= done_count_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_sum   = slot_q.sum;
    assign resp_carry = slot_q.carry;
    assign resp_id    = slot_q.id;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter (N_REQ=4, WIDTH=8, CNT_W=16).
// A behavioural model of the response slot is compared every cycle, and directed
// vectors carry hand-computed literal expectations.
module tb_adder_share_arbiter;
    import adder_share_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]  req_ready;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  resp_sum;
    logic          resp_carry;
    logic [1:0]    resp_id;
    logic [15:0]   done_count;

    int checks   = 0;
    int failures = 0;

    adder_share_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .ID_W  (2),
        .CNT_W (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_carry (resp_carry),
        .resp_id    (resp_id),
        .done_count (done_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_full  = 1'b0;
    logic [7:0]  m_sum   = '0;
    logic        m_carry = 1'b0;
    logic [1:0]  m_id    = '0;
    logic [15:0] m_cnt   = '0;
    int          m_ptr   = 0;

    function automatic int mwin(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        if (reset) return '0;
        if (m_full && !resp_ready) return '0;
        w = mwin(req_valid, m_ptr);
        if (w < 0) return '0;
        return 4'(1 << w);
    endfunction

    function automatic int opsum(input int w);
        return int'(req_a[w*W +: W]) + int'(req_b[w*W +: W]);
    endfunction

    function automatic resp_t exp_resp();
        resp_t r;
        r.id    = m_id;
        r.carry = m_carry;
        r.sum   = m_sum;
        return r;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_full  <= 1'b0;
            m_sum   <= '0;
            m_carry <= 1'b0;
            m_id    <= '0;
            m_cnt   <= '0;
            m_ptr   <= 0;
        end else begin
            if (m_full && resp_ready) m_cnt <= m_cnt + 16'd1;
            if (exp_ready() != '0) begin
                m_full  <= 1'b1;
                m_sum   <= 8'(opsum(mwin(req_valid, m_ptr)));
                m_carry <= (opsum(mwin(req_valid, m_ptr)) >= 256);
                m_id    <= 2'(mwin(req_valid, m_ptr));
                m_ptr   <= (mwin(req_valid, m_ptr) + 1) % N;
            end else if (resp_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    // Cycle compare on the falling edge, away from input changes and the active edge.
    always @(negedge clock) begin
        chk("model_req_ready", 32'(req_ready), 32'(exp_ready()));
        chk("model_resp_valid", 32'(resp_valid), 32'(m_full));
        chk("model_done_count", 32'(done_count), 32'(m_cnt));
        if (m_full) begin
            chk("model_resp", 32'({resp_id, resp_carry, resp_sum}), 32'(exp_resp()));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    initial begin
        // Reset: req_ready stays low even with every requester valid.
        reset      = 1'b1;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        tick();
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_resp_valid", 32'(resp_valid), 32'h0);
        chk("reset_done_count", 32'(done_count), 32'h0);
        chk("reset_resp", 32'({resp_id, resp_carry, resp_sum}), 32'h0);
        tick();
        reset     = 1'b0;
        req_valid = '0;
        tick();

        // Single request: 3 + 4 from requester 0.
        set_op(0, 8'd3, 8'd4);
        req_valid = 4'b0001;
        #1 chk("single_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("single_valid", 32'(resp_valid), 32'h1);
        chk("single_sum", 32'(resp_sum), 32'd7);
        chk("single_carry", 32'(resp_carry), 32'h0);
        chk("single_id", 32'(resp_id), 32'h0);
        chk("single_cnt_before", 32'(done_count), 32'h0);
        tick();
        chk("single_cnt_after", 32'(done_count), 32'h1);
        chk("single_empty", 32'(resp_valid), 32'h0);

        // Overflow from requester 3 (pointer is 1, so 3 wins and the pointer wraps to 0).
        set_op(3, 8'hF0, 8'h20);
        req_valid = 4'b1000;
        #1 chk("ovf_req_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        chk("ovf_sum", 32'(resp_sum), 32'h10);
        chk("ovf_carry", 32'(resp_carry), 32'h1);
        chk("ovf_id", 32'(resp_id), 32'h3);
        tick();
        chk("ovf_cnt", 32'(done_count), 32'h2);

        // Saturation: all valid, one grant per cycle in order 0,1,2,3,0,...
        for (int i = 0; i < N; i++) set_op(i, 8'(i * 10 + 1), 8'(i));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 chk("sat_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            chk("sat_valid", 32'(resp_valid), 32'h1);
            chk("sat_id", 32'(resp_id), 32'(k % 4));
            chk("sat_sum", 32'(resp_sum), 32'((k % 4) * 11 + 1));
        end
        req_valid = '0;
        tick();
        chk("sat_cnt", 32'(done_count), 32'd10);

        // Backpressure: id 2 result 5 held for three stalled cycles.
        set_op(2, 8'd2, 8'd3);
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        #1 chk("bp_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'hF;
        chk("bp_first_id", 32'(resp_id), 32'h2);
        chk("bp_first_sum", 32'(resp_sum), 32'd5);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_req_ready", 32'(req_ready), 32'h0);
            tick();
            chk("bp_hold_valid", 32'(resp_valid), 32'h1);
            chk("bp_hold_id", 32'(resp_id), 32'h2);
            chk("bp_hold_sum", 32'(resp_sum), 32'd5);
        end
        set_op(3, 8'd5, 8'd6);
        resp_ready = 1'b1;
        req_valid  = 4'b1000;
        #1 chk("bp_release_ready", 32'(req_ready), 32'h8);
        tick();
        chk("bp_b2b_valid", 32'(resp_valid), 32'h1);
        chk("bp_b2b_id", 32'(resp_id), 32'h3);
        chk("bp_b2b_sum", 32'(resp_sum), 32'd11);
        chk("bp_b2b_cnt", 32'(done_count), 32'd11);
        req_valid = '0;
        tick();
        chk("bp_cnt", 32'(done_count), 32'd12);

        // Pointer skip: grant 0 moves pointer to 1, then 1001 picks 3, then 0.
        req_valid = 4'b0001;
        #1 chk("skip_pre_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b1001;
        #1 chk("skip_ready_3", 32'(req_ready), 32'h8);
        tick();
        chk("skip_id_3", 32'(resp_id), 32'h3);
        #1 chk("skip_ready_0", 32'(req_ready), 32'h1);
        tick();
        chk("skip_id_0", 32'(resp_id), 32'h0);
        req_valid = '0;
        tick();
        chk("skip_cnt", 32'(done_count), 32'd15);

        // Async reset while a result is stalled (pointer is 2 before reset).
        set_op(1, 8'd9, 8'd9);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        #1 chk("ar_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("ar_stalled_valid", 32'(resp_valid), 32'h1);
        chk("ar_stalled_sum", 32'(resp_sum), 32'h12);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(resp_valid), 32'h0);
        chk("ar_cnt", 32'(done_count), 32'h0);
        chk("ar_resp", 32'({resp_id, resp_carry, resp_sum}), 32'h0);
        chk("ar_req_ready", 32'(req_ready), 32'h0);
        tick();
        reset      = 1'b0;
        req_valid  = 4'b1010;
        resp_ready = 1'b1;
        #1 chk("ar_post_ready", 32'(req_ready), 32'h2);
        tick();
        chk("ar_post_id", 32'(resp_id), 32'h1);
        chk("ar_post_sum", 32'(resp_sum), 32'h12);
        req_valid = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered 8-bit adder lane between N_REQ requesters.
- Each requester presents an operand pair under a valid/ready handshake.
- A round-robin arbiter grants one request per cycle.
- The sum is returned on a single response channel, tagged with the winner's index, and held under backpressure.
- Sits between multiple client blocks and the adder resource, so no client needs a private adder instance.

Parameters:
- N_REQ, 4, number of requesters; power of two, 2..8.
- WIDTH, 8, operand and sum width in bits.
- ID_W, $clog2(N_REQ), width of the requester tag.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_a  input  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B, packed the same way.
- req_ready  output  N_REQ  one-hot-or-zero grant; a transfer occurs on req_valid[i] & req_ready[i].
- resp_valid  output  1  response slot holds a result.
- resp_ready  input  1  consumer accepts the response this cycle.
- resp_sum  output  WIDTH  (a+b) truncated to WIDTH.
- resp_carry  output  1  carry-out, bit WIDTH of a+b.
- resp_id  output  ID_W  index of the requester that produced the result.
- done_count  output  CNT_W  count of responses consumed (resp_valid & resp_ready); wraps modulo 2^CNT_W.

Behaviour:
- Reset: resp_valid=0, resp_sum=0, resp_carry=0, resp_id=0, done_count=0, rr_ptr=0. req_ready is 0 while reset is asserted.
- Reset asserted mid-operation discards any held result. There is no partial transfer.
- Slot state machine (ST_EMPTY, ST_FULL):
  - ST_EMPTY -> ST_FULL on a grant.
  - ST_FULL -> ST_EMPTY on resp_ready with no new grant.
  - ST_FULL -> ST_FULL on resp_ready with a new grant (back-to-back).
  - ST_FULL holds while resp_ready=0.
- can_issue = (state==ST_EMPTY) | resp_ready.
- Arbitration (combinational):
  - When can_issue, the winner is the first index i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... wrapping mod N_REQ.
  - req_ready[winner]=1; all other bits are 0.
  - If no req_valid bit is set, req_ready=0.
  - When !can_issue, req_ready=0.
  - req_ready must not depend on resp_ready beyond can_issue, i.e. no path from req_valid to resp_ready.
- On a grant at edge t:
  - At t+1: resp_valid=1, resp_sum={carry,sum} = zero-extended a+b of the winner, resp_id=winner.
  - rr_ptr <= (winner+1) mod N_REQ.
- Latency is 1 cycle from accepted request to resp_valid. Throughput is 1/cycle with resp_ready held high.
- rr_ptr is unchanged on cycles with no grant.
- Backpressure: while resp_valid & !resp_ready, resp_sum, resp_carry and resp_id are held stable and no requester is granted.
- done_count increments on resp_valid & resp_ready. Wrap from 2^CNT_W-1 to 0 is silent.
- Simultaneous consume and grant in the same cycle: the old result retires, done_count increments, and the new result appears the next cycle without a bubble.
- Requesters may drop req_valid without a grant; the arbiter holds no state for ungranted requests.
- A requester stays ungranted at most N_REQ-1 grants after asserting valid (fairness).

Decomposition:
- Shared package adder_share_pkg holds: slot state enum (ST_EMPTY, ST_FULL), default WIDTH/N_REQ constants, and a packed resp_t struct {id, carry, sum}.
- One natural sub-module: rr_arbiter (N_REQ). Inputs: req vector, rr_ptr, enable. Output: one-hot grant plus encoded winner index. The adder datapath and slot register stay in the top level.

Test Plan:
- Single request: reset, then req_valid=0001, a=3, b=4, resp_ready=1 -> req_ready=0001 same cycle; next cycle resp_valid=1, sum=7, carry=0, id=0; done_count=1 after consume.
- Overflow: a=8'hF0, b=8'h20 -> sum=8'h10, carry=1.
- Round-robin under saturation: all four valid, resp_ready=1 for 8 cycles -> resp_id sequence 0,1,2,3,0,1,2,3; one response per cycle; done_count=8.
- Backpressure: result id=2 sum=5 held with resp_ready=0 for 3 cycles -> outputs stable, req_ready=0000. Raise resp_ready with req_valid=1000 -> old result consumed, id=3 result the next cycle with no gap.
- Pointer skip: rr_ptr=1, req_valid=1001 -> grant id=3, then rr_ptr=0 and the next grant is id=0.
- Async reset mid-stall: assert reset between edges while resp_valid=1 -> resp_valid, done_count and rr_ptr drop to 0 immediately without a clock edge; the first post-reset grant goes to the lowest valid index.
